// File: rtl/bpu_gen2.sv
// bpu_gen2 -- IF-stage branch predictor with ID-stage resolve/update.
//
// A direct-mapped table of 2^IDX_W entries (valid, tag, saturating direction
// counter, 32-bit target) is looked up combinationally with if_pc. The
// prediction and lookup index are registered as the ID-stage copy. In ID, the
// resolved outcome is compared against that copy (pred_error) and trains the
// entry selected by the registered index, tagged with id_pc.
//
// Optional feature: define BPU_RAS_EN to add a return address stack. Entries
// then carry a ret bit; a hit on a ret entry while the stack is non-empty
// predicts the stack top. Without the macro, call/ret inputs are ignored.
//
// Ports:
//   cpu_clk, cpu_rstn            clock (rising), async active-low reset
//   if_pc                        IF-stage PC
//   pred_taken, pred_target      IF prediction (combinational)
//   pred_error                   ID-stage misprediction flag
//   id_valid, id_is_bj,
//   id_is_call, id_is_ret, id_pc ID-stage instruction info
//   real_taken, real_target      resolved outcome
module bpu_gen2 #(
   parameter int IDX_W     = 8,
   parameter int TAG_W     = 12,
   parameter int CNT_W     = 2,
   parameter int RAS_DEPTH = 8
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        pred_error,
   input  logic        id_valid,
   input  logic        id_is_bj,
   input  logic        id_is_call,
   input  logic        id_is_ret,
   input  logic [31:0] id_pc,
   input  logic        real_taken,
   input  logic [31:0] real_target
);

   localparam int              NENT    = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);  // weakly taken
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] pc);
      return pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2];
   endfunction

   // table storage: valid/counter are reset, tag/target are don't-care
   logic [NENT-1:0]  tbl_vld;
   logic [CNT_W-1:0] tbl_cnt [NENT];
   logic [TAG_W-1:0] tbl_tag [NENT];
   logic [31:0]      tbl_tgt [NENT];

   // IF lookup
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = f_idx(if_pc);
   assign if_tag = if_pc[31:32-TAG_W];
   assign if_hit = tbl_vld[if_idx] && (tbl_tag[if_idx] == if_tag);

   // ID-stage copies
   logic [IDX_W-1:0] id_idx;
   logic             id_pred_taken;
   logic [31:0]      id_pred_target;

   // update decode
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit, do_cnt, do_alloc, do_scrub, do_tgt, exp_taken;

`ifdef BPU_RAS_EN
   localparam int RP_W = $clog2(RAS_DEPTH);

   logic             tbl_ret [NENT];
   logic [31:0]      ras_stk [RAS_DEPTH];
   logic [RP_W-1:0]  ras_ptr;   // next free slot; top is ras_ptr-1
   logic [RP_W:0]    ras_cnt;
   logic             do_push, do_pop;

   assign do_push = id_valid && id_is_call;
   assign do_pop  = id_valid && id_is_ret && (ras_cnt != '0);
`else
   logic unused_ok;
   localparam int unused_ras_depth = RAS_DEPTH;
   // returns are plain table entries in this build; only id_pc's tag is used
   assign unused_ok = ^{id_is_call, id_is_ret, id_pc};
`endif

   always_comb begin
      pred_taken  = if_hit && tbl_cnt[if_idx][CNT_W-1];
      pred_target = pred_taken ? tbl_tgt[if_idx] : if_pc + 32'd4;
`ifdef BPU_RAS_EN
      // a known return overrides the counter and uses the stack top
      if (if_hit && tbl_ret[if_idx] && (ras_cnt != '0)) begin
         pred_taken  = 1'b1;
         pred_target = ras_stk[ras_ptr - RP_W'(1)];
      end
`endif
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         id_idx         <= '0;
         id_pred_taken  <= 1'b0;
         id_pred_target <= '0;
      end else begin
         id_idx         <= if_idx;
         id_pred_taken  <= pred_taken;
         id_pred_target <= pred_target;
      end
   end

   assign exp_taken  = id_is_bj && real_taken;
   assign pred_error = id_valid && ((id_pred_taken != exp_taken) ||
                                    (exp_taken && (id_pred_target != real_target)));

   // training uses the registered index, so it targets the slot that
   // produced the ID-stage prediction
   assign upd_tag  = id_pc[31:32-TAG_W];
   assign upd_hit  = tbl_vld[id_idx] && (tbl_tag[id_idx] == upd_tag);
   assign do_cnt   = id_valid && id_is_bj && upd_hit;
   assign do_alloc = id_valid && id_is_bj && !upd_hit && real_taken;
   assign do_scrub = id_valid && !id_is_bj && upd_hit;   // non-branch aliasing an entry
   assign do_tgt   = do_alloc || (do_cnt && real_taken);

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         tbl_vld <= '0;
         for (int i = 0; i < NENT; i++) tbl_cnt[i] <= CNT_WT;
      end else if (do_alloc) begin
         tbl_vld[id_idx] <= 1'b1;
         tbl_cnt[id_idx] <= CNT_WT;
      end else if (do_scrub) begin
         tbl_vld[id_idx] <= 1'b0;
      end else if (do_cnt) begin
         if (real_taken && tbl_cnt[id_idx] != CNT_MAX)
            tbl_cnt[id_idx] <= tbl_cnt[id_idx] + CNT_W'(1);
         else if (!real_taken && tbl_cnt[id_idx] != '0)
            tbl_cnt[id_idx] <= tbl_cnt[id_idx] - CNT_W'(1);
      end
   end

   // Payload is not reset: a write landing on a reset edge is harmless
   // because the entry's valid bit is cleared by the same reset.
   always_ff @(posedge cpu_clk) begin
      if (do_tgt) begin
         tbl_tag[id_idx] <= upd_tag;
         tbl_tgt[id_idx] <= real_target;
`ifdef BPU_RAS_EN
         tbl_ret[id_idx] <= id_is_ret;
`endif
      end
   end

`ifdef BPU_RAS_EN
   // Circular stack: when full, a push lands on the oldest slot. Call+ret
   // together is pop-then-push, i.e. the top is replaced in place.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (do_push && !do_pop) begin
         ras_ptr <= ras_ptr + RP_W'(1);
         if (ras_cnt != (RP_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RP_W+1)'(1);
      end else if (do_pop && !do_push) begin
         ras_ptr <= ras_ptr - RP_W'(1);
         ras_cnt <= ras_cnt - (RP_W+1)'(1);
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (do_push) ras_stk[do_pop ? ras_ptr - RP_W'(1) : ras_ptr] <= id_pc + 32'd4;
   end
`endif

endmodule

// File: tb/tb_bpu_gen2.sv
module tb_bpu_gen2;
   localparam int IDX_W = 8, TAG_W = 12, CNT_W = 2, RAS_DEPTH = 8;
   localparam int NENT = 1 << IDX_W;
   localparam int CMAX = (1 << CNT_W) - 1;
   localparam int CWT  = 1 << (CNT_W - 1);

   logic        cpu_clk = 1'b0, cpu_rstn = 1'b0;
   logic [31:0] if_pc = '0, id_pc = '0, real_target = '0;
   logic        id_valid = 1'b0, id_is_bj = 1'b0, id_is_call = 1'b0, id_is_ret = 1'b0;
   logic        real_taken = 1'b0;
   logic        pred_taken, pred_error;
   logic [31:0] pred_target;

   bpu_gen2 #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)) dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_error(pred_error),
      .id_valid(id_valid), .id_is_bj(id_is_bj), .id_is_call(id_is_call),
      .id_is_ret(id_is_ret), .id_pc(id_pc), .real_taken(real_taken),
      .real_target(real_target));

   always #5 cpu_clk = ~cpu_clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic [31:0] ip, input logic v, bj, call, ret,
                        input logic [31:0] ipc, input logic rt, input logic [31:0] rtg);
      if_pc = ip; id_valid = v; id_is_bj = bj; id_is_call = call; id_is_ret = ret;
      id_pc = ipc; real_taken = rt; real_target = rtg;
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_vld [NENT];
   int          m_cnt [NENT];
   logic [TAG_W-1:0] m_tag [NENT];
   logic [31:0] m_tgt [NENT];
   bit          m_ret [NENT];
   logic [31:0] m_ras [$];
   int          m_id_idx;
   bit          m_id_taken;
   logic [31:0] m_id_tgt;

   function automatic int midx(input logic [31:0] pc);
      return int'(((pc >> 2) ^ (pc >> (IDX_W + 2))) & (NENT - 1));
   endfunction

   function automatic logic [TAG_W-1:0] mtag(input logic [31:0] pc);
      return TAG_W'(pc >> (32 - TAG_W));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) begin m_vld[i] = 0; m_cnt[i] = CWT; m_ret[i] = 0; end
      m_ras.delete();
      m_id_idx = 0; m_id_taken = 0; m_id_tgt = '0;
   endtask

   task automatic model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
      int i = midx(pc);
      bit hit = m_vld[i] && m_tag[i] == mtag(pc);
      t  = hit && (m_cnt[i] >= CWT);
      tg = t ? m_tgt[i] : pc + 32'd4;
`ifdef BPU_RAS_EN
      if (hit && m_ret[i] && m_ras.size() > 0) begin t = 1; tg = m_ras[$]; end
`endif
   endtask

   function automatic bit model_err(input bit v, bj, rt, input logic [31:0] rtg);
      bit ex = bj && rt;
      return v && ((m_id_taken != ex) || (ex && m_id_tgt != rtg));
   endfunction

   // applied at the clock edge; pt/ptg is the pre-edge prediction for if_pc
   task automatic model_commit(input logic [31:0] ip, input bit v, bj, call, ret,
                               input logic [31:0] ipc, input bit rt,
                               input logic [31:0] rtg, input bit pt, input logic [31:0] ptg);
      int i = m_id_idx;
      bit hit = m_vld[i] && m_tag[i] == mtag(ipc);
      if (v) begin
         if (bj && hit) begin
            m_cnt[i] = rt ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                          : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (rt) begin m_tgt[i] = rtg; m_ret[i] = ret; end
         end else if (bj && rt) begin
            m_vld[i] = 1; m_tag[i] = mtag(ipc); m_tgt[i] = rtg; m_cnt[i] = CWT; m_ret[i] = ret;
         end else if (!bj && hit) begin
            m_vld[i] = 0;
         end
`ifdef BPU_RAS_EN
         if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
         if (call) begin
            m_ras.push_back(ipc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
         end
`endif
      end
      m_id_idx = midx(ip); m_id_taken = pt; m_id_tgt = ptg;
   endtask

   function automatic logic [31:0] pool_pc();
      logic [11:0] tags [3] = '{12'h1C0, 12'h2C0, 12'h3C0};
      return {tags[$urandom_range(0, 2)], 20'h0} | (32'($urandom_range(0, 3)) << 2);
   endfunction

   task automatic do_reset();
      cpu_rstn = 1'b0;
      drive(32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      repeat (2) @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      model_reset();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0] ip;  logic v; logic bj; logic [31:0] ipc; logic rt; logic [31:0] rtg;
      logic et; logic [31:0] etg; logic ee;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] ip, input logic v, bj,
                               input logic [31:0] ipc, input logic rt, input logic [31:0] rtg,
                               input logic et, input logic [31:0] etg, input logic ee);
      vec_t r;
      r.ip = ip; r.v = v; r.bj = bj; r.ipc = ipc; r.rt = rt; r.rtg = rtg;
      r.et = et; r.etg = etg; r.ee = ee;
      return r;
   endfunction

   vec_t vt [19];

   initial begin
      bit          et;
      logic [31:0] etg;
      bit          ee;
      logic [31:0] prev_if;

      vt[0]  = mk(32'h1C000000, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1C000004, 0);
      vt[1]  = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1C000104, 0);
      vt[2]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 1, 32'h1C000200, 0, 32'h1C000104, 1);
      vt[3]  = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1C000200, 0);
      vt[4]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 0, 32'h0,        1, 32'h1C000200, 1);
      vt[5]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 0, 32'h0,        0, 32'h1C000104, 1);
      vt[6]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 0, 32'h0,        0, 32'h1C000104, 0);
      vt[7]  = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1C000104, 0);
      vt[8]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 1, 32'h1C000200, 0, 32'h1C000104, 1);
      vt[9]  = mk(32'h1C000100, 1, 1, 32'h1C000100, 1, 32'h1C000200, 0, 32'h1C000104, 1);
      vt[10] = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1C000200, 0);
      vt[11] = mk(32'h2C000100, 0, 0, 32'h0,        0, 32'h0,        0, 32'h2C000104, 0);
      vt[12] = mk(32'h2C000100, 1, 1, 32'h2C000100, 0, 32'h0,        0, 32'h2C000104, 0);
      vt[13] = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1C000200, 0);
      vt[14] = mk(32'h2C000100, 1, 1, 32'h2C000100, 1, 32'h2C000300, 0, 32'h2C000104, 1);
      vt[15] = mk(32'h1C000100, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1C000104, 0);
      vt[16] = mk(32'h2C000100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h2C000300, 0);
      vt[17] = mk(32'h2C000100, 1, 0, 32'h2C000100, 0, 32'h0,        1, 32'h2C000300, 1);
      vt[18] = mk(32'h2C000100, 0, 0, 32'h0,        0, 32'h0,        0, 32'h2C000104, 0);

      do_reset();
      for (int r = 0; r < 19; r++) begin
         drive(vt[r].ip, vt[r].v, vt[r].bj, 0, 0, vt[r].ipc, vt[r].rt, vt[r].rtg);
         #2;
         chk($sformatf("vec%0d taken", r),  32'(pred_taken), 32'(vt[r].et));
         chk($sformatf("vec%0d target", r), pred_target, vt[r].etg);
         chk($sformatf("vec%0d error", r),  32'(pred_error), 32'(vt[r].ee));
         @(posedge cpu_clk); @(negedge cpu_clk);
      end

      // reset landing on an allocating update: the allocation must be lost
      drive(32'h1C000800, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      @(posedge cpu_clk); @(negedge cpu_clk);
      drive(32'h1C000800, 1, 1, 0, 0, 32'h1C000800, 1, 32'h1C000900);
      #2 cpu_rstn = 1'b0;
      @(posedge cpu_clk); @(negedge cpu_clk);
      drive(32'h1C000800, 1, 1, 0, 0, 32'h1C000800, 0, 32'h0);
      cpu_rstn = 1'b1;
      #2;
      chk("rst_mid taken",  32'(pred_taken), 32'd0);
      chk("rst_mid target", pred_target, 32'h1C000804);
      chk("rst_mid error",  32'(pred_error), 32'd0);
      @(posedge cpu_clk); @(negedge cpu_clk);

      // randomized traffic against the model
      do_reset();
      prev_if = '0;
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] ip, ipc, rtg;
         bit v, bj, call, ret, rt;
         ip   = pool_pc();
         ipc  = ($urandom_range(0, 4) != 0) ? prev_if : pool_pc();
         v    = $urandom_range(0, 3) != 0;
         bj   = $urandom_range(0, 4) != 0;
         rt   = $urandom_range(0, 1) != 0;
         call = $urandom_range(0, 3) == 0;
         ret  = $urandom_range(0, 3) == 0;
         rtg  = pool_pc() + 32'h40;
         drive(ip, v, bj, call, ret, ipc, rt, rtg);
         model_predict(ip, et, etg);
         ee = model_err(v, bj, rt, rtg);
         #2;
         chk("rnd taken",  32'(pred_taken), 32'(et));
         chk("rnd target", pred_target, etg);
         chk("rnd error",  32'(pred_error), 32'(ee));
         @(posedge cpu_clk);
         model_commit(ip, v, bj, call, ret, ipc, rt, rtg, et, etg);
         @(negedge cpu_clk);
         prev_if = ip;
      end

`ifdef BPU_RAS_EN
      // return-stack overflow and drain
      do_reset();
      drive(32'h1C000500, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      @(posedge cpu_clk); @(negedge cpu_clk);
      drive(32'h1C000010, 1, 1, 0, 1, 32'h1C000500, 1, 32'h1C000600);
      @(posedge cpu_clk); @(negedge cpu_clk);
      for (int k = 0; k < 9; k++) begin
         drive((k < 8) ? 32'h1C000010 + 32'(16 * (k + 1)) : 32'h1C000500,
               1, 0, 1, 0, 32'h1C000010 + 32'(16 * k), 0, 32'h0);
         @(posedge cpu_clk); @(negedge cpu_clk);
      end
      for (int j = 0; j < 10; j++) begin
         drive(32'h1C000500, 1, 1, 0, 1, 32'h1C000500, 1, 32'h1C000600);
         #2;
         chk($sformatf("ras pop%0d taken", j), 32'(pred_taken), 32'd1);
         chk($sformatf("ras pop%0d target", j), pred_target,
             (j < 8) ? 32'h1C000094 - 32'(16 * j) : 32'h1C000600);
         @(posedge cpu_clk); @(negedge cpu_clk);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
